// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the multi-channel stopwatch:
// register offsets, bit indices, AXI responses, channel strobes.
package stopwatch_ctrl_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_COUNT  = 2'd1;
  localparam logic [1:0] REG_LAP    = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_RUN     = 0;
  localparam int CTRL_CLEAR   = 1;
  localparam int CTRL_LAP     = 2;
  localparam int CTRL_WRAP_IE = 3;

  localparam int STAT_RUNNING = 0;
  localparam int STAT_WRAP    = 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // run/wrap_ie are levels; clear/lap/wrap_w1c are one-cycle pulses
  typedef struct packed {
    logic run;
    logic clear;
    logic lap;
    logic wrap_ie;
    logic wrap_w1c;
  } ch_ctl_t;

endpackage

// File: rtl/stopwatch_channel.sv
// One stopwatch channel: counter, lap capture, sticky wrap flag.
// Ports: clk/rst_n, tick, ctl strobes in; count, lap, wrap, irq_src out.
module stopwatch_channel
  import stopwatch_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  ch_ctl_t          ctl,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] lap,
  output logic             wrap,
  output logic             irq_src
);

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] lap_q, lap_d;
  logic             wrap_q, wrap_d;
  logic             inc;

  always_comb begin
    inc     = tick && ctl.run;
    count_d = count_q;
    lap_d   = lap_q;
    wrap_d  = wrap_q;
    if (ctl.lap) lap_d = count_q;
    if (ctl.clear) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + CNT_W'(1);
    end
    if (ctl.wrap_w1c) wrap_d = 1'b0;
    // a wrap beats a simultaneous W1C
    if (inc && !ctl.clear && (&count_q)) wrap_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      lap_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      lap_q   <= lap_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count   = count_q;
  assign lap     = lap_q;
  assign wrap    = wrap_q;
  assign irq_src = wrap_q && ctl.wrap_ie;

endmodule

// File: rtl/multi_stopwatch_axil.sv
// AXI4-Lite slave with NUM_CH stopwatch channels at k*0x10.
// Ports: AXI4-Lite slave (S_AXI_*), ACLK/ARESETN, level irq.
module multi_stopwatch_axil
  import stopwatch_ctrl_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int NUM_CH             = 4,
  parameter int CNT_W              = 32,
  parameter int PRESCALE           = 100
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            irq
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0]     presc_q, presc_d;
  logic              tick;
  logic [NUM_CH-1:0] run_q, run_d, ie_q, ie_d;
  logic [NUM_CH-1:0] clr, lapv, w1c, irq_src;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              rvalid_q, rvalid_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              irq_q, irq_d;
  logic              wr_acc, ar_acc, aw_ok, ar_ok;
  logic [31:0]       aw_ch, ar_ch;
  logic [1:0]        aw_reg, ar_reg;
  logic              unused_ok;

  logic [CNT_W-1:0]  cnt [NUM_CH];
  logic [CNT_W-1:0]  lp  [NUM_CH];
  logic              wrp [NUM_CH];
  ch_ctl_t           ctl [NUM_CH];

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                       S_AXI_WSTRB[C_S_AXI_DATA_WIDTH/8-1:1],
                       S_AXI_WDATA[C_S_AXI_DATA_WIDTH-1:4]};

  always_comb begin
    tick    = (presc_q == PW'(PRESCALE - 1));
    presc_d = tick ? '0 : presc_q + PW'(1);
  end

  always_comb begin
    wr_acc   = S_AXI_AWVALID && S_AXI_WVALID && !bvalid_q;
    aw_ch    = 32'(S_AXI_AWADDR) >> 4;
    aw_reg   = S_AXI_AWADDR[3:2];
    aw_ok    = aw_ch < 32'(NUM_CH);
    run_d    = run_q;
    ie_d     = ie_q;
    clr      = '0;
    lapv     = '0;
    w1c      = '0;
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    if (bvalid_q && S_AXI_BREADY) bvalid_d = 1'b0;
    if (wr_acc) begin
      bvalid_d = 1'b1;
      bresp_d  = aw_ok ? RESP_OKAY : RESP_SLVERR;
    end
    for (int k = 0; k < NUM_CH; k++) begin
      if (wr_acc && aw_ok && S_AXI_WSTRB[0] && aw_ch == 32'(k)) begin
        unique case (1'b1)
          aw_reg == REG_CTRL: begin
            run_d[k] = S_AXI_WDATA[CTRL_RUN];
            ie_d[k]  = S_AXI_WDATA[CTRL_WRAP_IE];
            clr[k]   = S_AXI_WDATA[CTRL_CLEAR];
            lapv[k]  = S_AXI_WDATA[CTRL_LAP];
          end
          aw_reg == REG_STATUS: w1c[k] = S_AXI_WDATA[STAT_WRAP];
          default: ;
        endcase
      end
    end
  end

  // read path samples pre-write state, so a same-cycle write is not visible
  always_comb begin
    ar_acc   = S_AXI_ARVALID && !rvalid_q;
    ar_ch    = 32'(S_AXI_ARADDR) >> 4;
    ar_reg   = S_AXI_ARADDR[3:2];
    ar_ok    = ar_ch < 32'(NUM_CH);
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (rvalid_q && S_AXI_RREADY) rvalid_d = 1'b0;
    if (ar_acc) begin
      rvalid_d = 1'b1;
      rresp_d  = ar_ok ? RESP_OKAY : RESP_SLVERR;
      rdata_d  = '0;
      for (int k = 0; k < NUM_CH; k++) begin
        if (ar_ok && ar_ch == 32'(k)) begin
          unique case (1'b1)
            ar_reg == REG_CTRL: begin
              rdata_d[CTRL_RUN]     = run_q[k];
              rdata_d[CTRL_WRAP_IE] = ie_q[k];
            end
            ar_reg == REG_COUNT: rdata_d = 32'(cnt[k]);
            ar_reg == REG_LAP:   rdata_d = 32'(lp[k]);
            ar_reg == REG_STATUS: begin
              rdata_d[STAT_RUNNING] = run_q[k];
              rdata_d[STAT_WRAP]    = wrp[k];
            end
            default: ;
          endcase
        end
      end
    end
    irq_d = |irq_src;
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign ctl[k] = '{run: run_q[k], clear: clr[k], lap: lapv[k],
                      wrap_ie: ie_q[k], wrap_w1c: w1c[k]};
    stopwatch_channel #(.CNT_W(CNT_W)) u_ch (
      .clk     (ACLK),
      .rst_n   (ARESETN),
      .tick    (tick),
      .ctl     (ctl[k]),
      .count   (cnt[k]),
      .lap     (lp[k]),
      .wrap    (wrp[k]),
      .irq_src (irq_src[k])
    );
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      presc_q  <= '0;
      run_q    <= '0;
      ie_q     <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
      rvalid_q <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      run_q    <= run_d;
      ie_q     <= ie_d;
      bvalid_q <= bvalid_d;
      bresp_q  <= bresp_d;
      rvalid_q <= rvalid_d;
      rresp_q  <= rresp_d;
      rdata_q  <= rdata_d;
      irq_q    <= irq_d;
    end
  end

  // ARESETN gating keeps READY low while reset is held
  assign S_AXI_AWREADY = wr_acc && ARESETN;
  assign S_AXI_WREADY  = wr_acc && ARESETN;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = !rvalid_q && ARESETN;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;
  assign irq           = irq_q;

endmodule

// File: tb/tb_multi_stopwatch_axil.sv
// Randomized scoreboard bench for multi_stopwatch_axil.
// Reference model tracks channel state per clock from the register rules.
module tb_multi_stopwatch_axil;

  localparam int AW = 7;
  localparam int NCH = 4;
  localparam int CW = 4;
  localparam int PS = 3;
  localparam int MAXC = (1 << CW) - 1;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } rd_t;

  logic          ACLK = 1'b0;
  logic          ARESETN = 1'b0;
  logic [AW-1:0] AWADDR = '0, ARADDR = '0;
  logic          AWVALID = 0, WVALID = 0, ARVALID = 0;
  logic          BREADY = 0, RREADY = 0;
  logic [31:0]   WDATA = '0;
  logic [3:0]    WSTRB = '0;
  logic          AWREADY, WREADY, BVALID, ARREADY, RVALID, IRQ;
  logic [1:0]    BRESP, RRESP;
  logic [31:0]   RDATA;

  int n_chk = 0, n_fail = 0;
  bit hold_b = 0, hold_r = 0;

  int m_cnt [NCH], m_lap [NCH];
  bit m_run [NCH], m_ie [NCH], m_wrap [NCH];
  bit m_irq;
  int cyc;
  rd_t rq [$];
  logic [1:0] bq [$];

  multi_stopwatch_axil #(
    .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(AW),
    .NUM_CH(NCH), .CNT_W(CW), .PRESCALE(PS)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWADDR(AWADDR), .S_AXI_AWPROT(3'b0),
    .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(AWREADY),
    .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB),
    .S_AXI_WVALID(WVALID), .S_AXI_WREADY(WREADY),
    .S_AXI_BRESP(BRESP), .S_AXI_BVALID(BVALID),
    .S_AXI_BREADY(BREADY),
    .S_AXI_ARADDR(ARADDR), .S_AXI_ARPROT(3'b0),
    .S_AXI_ARVALID(ARVALID), .S_AXI_ARREADY(ARREADY),
    .S_AXI_RDATA(RDATA), .S_AXI_RRESP(RRESP),
    .S_AXI_RVALID(RVALID), .S_AXI_RREADY(RREADY),
    .irq(IRQ)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic rd_t model_rd(input logic [AW-1:0] a);
    rd_t r;
    int ch;
    logic [1:0] rg;
    ch = int'(a) / 16;
    rg = a[3:2];
    r.data = 0;
    r.resp = 2'b00;
    if (ch >= NCH) begin
      r.resp = 2'b10;
    end else begin
      case (rg)
        2'd0: r.data = 32'(m_run[ch]) + 32'(m_ie[ch]) * 8;
        2'd1: r.data = 32'(m_cnt[ch]);
        2'd2: r.data = 32'(m_lap[ch]);
        default: r.data = 32'(m_run[ch]) + 32'(m_wrap[ch]) * 2;
      endcase
    end
    return r;
  endfunction

  // reference model: applies accepted writes and ticks per clock edge
  initial begin
    forever begin
      @(posedge ACLK);
      if (!ARESETN) begin
        for (int k = 0; k < NCH; k++) begin
          m_cnt[k] = 0; m_lap[k] = 0;
          m_run[k] = 0; m_ie[k] = 0; m_wrap[k] = 0;
        end
        m_irq = 0;
        cyc = 0;
      end else begin
        bit tick, wr;
        int wch;
        logic [1:0] wrg;
        tick = (cyc % PS) == PS - 1;
        if (ARVALID && ARREADY) rq.push_back(model_rd(ARADDR));
        wr = AWVALID && WVALID && AWREADY && WREADY;
        wch = int'(AWADDR) / 16;
        wrg = AWADDR[3:2];
        if (wr) bq.push_back(wch >= NCH ? 2'b10 : 2'b00);
        m_irq = 0;
        for (int k = 0; k < NCH; k++) m_irq |= m_wrap[k] && m_ie[k];
        for (int k = 0; k < NCH; k++) begin
          bit hit, clr, lp, wc, wset;
          hit = wr && wch == k && WSTRB[0];
          clr = hit && wrg == 0 && WDATA[1];
          lp = hit && wrg == 0 && WDATA[2];
          wc = hit && wrg == 3 && WDATA[1];
          wset = 0;
          if (lp) m_lap[k] = m_cnt[k];
          if (clr) m_cnt[k] = 0;
          else if (tick && m_run[k]) begin
            wset = (m_cnt[k] == MAXC);
            m_cnt[k] = (m_cnt[k] + 1) % (MAXC + 1);
          end
          if (wc) m_wrap[k] = 0;
          if (wset) m_wrap[k] = 1;
          if (hit && wrg == 0) begin
            m_run[k] = WDATA[0];
            m_ie[k] = WDATA[3];
          end
        end
        cyc++;
      end
    end
  end

  // monitor: pops expectations when the DUT completes a response
  initial begin
    forever begin
      @(posedge ACLK);
      if (ARESETN) begin
        if (RVALID && RREADY) begin
          if (rq.size() == 0) chk("r_unexpected", 1, 0);
          else begin
            rd_t e;
            e = rq.pop_front();
            chk("rdata", RDATA, e.data);
            chk("rresp", 32'(RRESP), 32'(e.resp));
          end
        end
        if (BVALID && BREADY) begin
          if (bq.size() == 0) chk("b_unexpected", 1, 0);
          else chk("bresp", 32'(BRESP), 32'(bq.pop_front()));
        end
      end
    end
  end

  // handshake rules and irq, sampled mid-cycle
  initial begin
    forever begin
      @(negedge ACLK);
      #2;
      if (ARESETN) begin
        chk("awready", 32'(AWREADY), 32'(AWVALID && WVALID && !BVALID));
        chk("wready", 32'(WREADY), 32'(AWVALID && WVALID && !BVALID));
        chk("arready", 32'(ARREADY), 32'(!RVALID));
        chk("irq", 32'(IRQ), 32'(m_irq));
      end
    end
  end

  initial begin
    forever begin
      @(negedge ACLK);
      BREADY = hold_b ? 1'b0 : ($urandom_range(0, 3) != 0);
      RREADY = hold_r ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d,
                    input logic [3:0] s, input int lead);
    int n;
    @(negedge ACLK);
    AWADDR = a; WDATA = d; WSTRB = s; AWVALID = 1;
    for (int i = 0; i < lead; i++) begin
      #1;
      chk("aw_alone_ready", 32'(AWREADY || WREADY), 0);
      @(negedge ACLK);
    end
    WVALID = 1;
    #1;
    n = 0;
    while (!(AWREADY && WREADY) && n < 200) begin
      @(negedge ACLK); #1; n++;
    end
    if (n >= 200) chk("wr_timeout", 1, 0);
    @(negedge ACLK);
    AWVALID = 0; WVALID = 0;
  endtask

  task automatic rd(input logic [AW-1:0] a);
    int n;
    @(negedge ACLK);
    ARADDR = a; ARVALID = 1;
    #1;
    n = 0;
    while (!ARREADY && n < 200) begin
      @(negedge ACLK); #1; n++;
    end
    if (n >= 200) chk("rd_timeout", 1, 0);
    @(negedge ACLK);
    ARVALID = 0;
  endtask

  initial begin
    AWVALID = 1; WVALID = 1; ARVALID = 1;
    repeat (3) @(negedge ACLK);
    #1;
    chk("rst_awready", 32'(AWREADY), 0);
    chk("rst_wready", 32'(WREADY), 0);
    chk("rst_arready", 32'(ARREADY), 0);
    chk("rst_bvalid", 32'(BVALID), 0);
    chk("rst_bresp", 32'(BRESP), 0);
    chk("rst_rvalid", 32'(RVALID), 0);
    chk("rst_rresp", 32'(RRESP), 0);
    chk("rst_rdata", RDATA, 0);
    chk("rst_irq", 32'(IRQ), 0);
    AWVALID = 0; WVALID = 0; ARVALID = 0;
    @(negedge ACLK);
    ARESETN = 1;

    for (int a = 0; a < 128; a += 4) rd(AW'(a));

    wr(7'h00, 32'h1, 4'hf, 0);
    rd(7'h0C);
    repeat (40) @(negedge ACLK);
    wr(7'h00, 32'h0, 4'hf, 0);
    rd(7'h04);
    rd(7'h0C);

    wr(7'h20, 32'h1, 4'hf, 0);
    repeat (20) @(negedge ACLK);
    wr(7'h20, 32'h5, 4'hf, 0);
    rd(7'h28);
    rd(7'h24);
    wr(7'h20, 32'h3, 4'hf, 0);
    rd(7'h24);
    rd(7'h2C);

    wr(7'h10, 32'h9, 4'hf, 0);
    repeat (60) @(negedge ACLK);
    rd(7'h1C);
    rd(7'h14);
    wr(7'h1C, 32'h2, 4'hf, 0);
    rd(7'h1C);

    wr(7'h40, 32'hF, 4'hf, 0);
    rd(7'h44);
    wr(7'h30, 32'h1, 4'he, 0);
    rd(7'h30);

    wr(7'h30, 32'h1, 4'hf, 5);
    hold_b = 1;
    wr(7'h00, 32'h1, 4'hf, 0);
    fork
      wr(7'h30, 32'h0, 4'hf, 0);
      begin
        repeat (10) begin
          @(negedge ACLK); #1;
          chk("bhold_bvalid", 32'(BVALID), 1);
          chk("bhold_awready", 32'(AWREADY), 0);
        end
        hold_b = 0;
      end
    join
    hold_r = 1;
    fork
      rd(7'h04);
      begin
        repeat (8) @(negedge ACLK);
        hold_r = 0;
      end
    join

    repeat (300) begin
      logic [AW-1:0] a;
      logic [31:0] d;
      a = AW'($urandom);
      d = $urandom;
      repeat ($urandom_range(0, 3)) @(negedge ACLK);
      if ($urandom_range(0, 1) == 1)
        wr(a, d, ($urandom_range(0, 3) != 0) ? 4'hf : 4'($urandom) & 4'he, 0);
      else
        rd(a);
    end

    begin
      int n = 0;
      while ((rq.size() != 0 || bq.size() != 0) && n < 1000) begin
        @(negedge ACLK); n++;
      end
      if (n >= 1000) chk("drain_timeout", 1, 0);
    end
    repeat (2) @(negedge ACLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_stopwatch_axil.md
Name: multi_stopwatch_axil

Overview:
AXI4-Lite slave holding NUM_CH independent stopwatch channels behind one register map. It is the parametrised successor to the single four-register stopwatch controller. Each channel has run/clear/lap control, a live count, a captured lap value and sticky wrap status. All channels advance on a shared prescaled tick. The block sits on the PS GP port through the interconnect and is exercised by the AXI VIP master in the BFM design.

Parameters:
C_S_AXI_DATA_WIDTH, 32, bus data width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 6, byte address width; must satisfy 2**C_S_AXI_ADDR_WIDTH >= NUM_CH*16.
NUM_CH, 4, number of stopwatch channels (1..16).
CNT_W, 32, counter width (1..32); the register is zero-extended to 32 bits on read.
PRESCALE, 100, ACLK cycles per tick (>=1); PRESCALE=1 means a tick every cycle.

Ports:
ACLK  in  1  clock
ARESETN  in  1  asynchronous active-low reset
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  AW handshake
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte strobes
S_AXI_WVALID / S_AXI_WREADY  in/out  1  W handshake
S_AXI_BRESP  out  2  write response
S_AXI_BVALID / S_AXI_BREADY  out/in  1  B handshake
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  AR handshake
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID / S_AXI_RREADY  out/in  1  R handshake
irq  out  1  level interrupt: OR over channels of (wrap sticky AND wrap_ie)

Behaviour:
- Reset: async assert on ARESETN low, sync release. All READY/VALID outputs are 0, RESP is 0, RDATA is 0, irq is 0. Prescaler, counts, laps, status and CTRL are all 0.
- Address map: channel k at k*0x10. Decode uses bits [5:4] and above for the channel and [3:2] for the register. Bits [1:0] are ignored.
  - +0x0 CTRL, RW: bit0 run; bit1 clear (W1, self-clearing, reads 0); bit2 lap (W1, self-clearing, reads 0); bit3 wrap_ie.
  - +0x4 COUNT, RO.
  - +0x8 LAP, RO.
  - +0xC STATUS: bit0 running (RO); bit1 wrap (sticky, W1C).
- Channel index >= NUM_CH: write is discarded with BRESP=SLVERR (2'b10); read returns RDATA=0 with RRESP=SLVERR. Writes to RO fields are ignored with OKAY.
- WSTRB: CTRL and STATUS bits live in byte 0. The write takes effect only if WSTRB[0]=1; otherwise it is a no-op with OKAY.
- Write channel:
  - AWREADY and WREADY both assert, in the same cycle, only when AWVALID && WVALID && !BVALID. AW and W are accepted together.
  - Register update is in the acceptance cycle. BVALID rises the next cycle and holds until BREADY.
  - Only one write is outstanding at a time.
- Read channel:
  - ARREADY=1 when !RVALID. The address is captured on the handshake.
  - RDATA/RRESP are registered and RVALID rises the next cycle. RDATA is stable until RREADY.
  - Read latency is 1 cycle from the AR handshake to RVALID.
- Read/write concurrency: reads and writes are independent. A same-cycle read of a register being written returns the pre-write value.
- Prescaler:
  - Free-running counter 0..PRESCALE-1.
  - tick=1 in the cycle it equals PRESCALE-1, then it wraps to 0.
  - It is never cleared by software.
- Channel counter:
  - On tick with run=1, count increments by 1.
  - At all-ones it wraps to 0 and sets wrap=1.
- Same-cycle priority per channel: clear > increment.
  - clear zeroes the count and leaves run and wrap unchanged.
  - lap captures the pre-increment count. With a simultaneous clear, lap captures the pre-clear value.
  - A wrap in the same cycle as a W1C of wrap: set wins.
- running = run.
- irq is registered; it updates 1 cycle after a status change.
- Reset mid-transaction: all handshakes drop immediately. The master must restart after reset.

Decomposition:
- Package stopwatch_ctrl_pkg holds:
  - register offsets (CTRL, COUNT, LAP, STATUS);
  - CTRL and STATUS bit indices;
  - RESP_OKAY and RESP_SLVERR;
  - a typedef for the per-channel control strobe struct (run, clear, lap, wrap_ie, wrap_w1c).
- Sub-module stopwatch_channel (one counter, lap register and wrap flag) is instantiated NUM_CH times in a generate loop.
- The AXI4-Lite front end, address decode and prescaler stay in the top level.

Test Plan:
- Reset then read 0x00..0x3C with default params -> every RDATA = 0, RRESP = OKAY.
- PRESCALE=4: write 0x00=0x1, wait 40 cycles, write 0x00=0x0, read 0x04 -> 10 (±1 tick); STATUS 0x0C bit0 reads 1 while running, 0 after stop.
- Ch2 running: write 0x20=0x5 (run+lap) when count=7 -> LAP 0x28 = 7, count continues; write 0x20=0x3 -> COUNT 0x24 = 0 next read, run still 1.
- CNT_W=4, PRESCALE=1, ch1 CTRL=0x9 -> after 16 ticks COUNT=0, STATUS=0x3, irq=1; write 0x1C=0x2 -> wrap and irq clear.
- Write 0x40 with C_S_AXI_ADDR_WIDTH=7, NUM_CH=4 -> BRESP=SLVERR, no register changes; read 0x44 -> RDATA=0, RRESP=SLVERR.
- Handshake stress:
  - AWVALID held 5 cycles before WVALID -> AWREADY stays 0 until both are valid.
  - BREADY held low 10 cycles -> BVALID held and no second write is accepted.
  - RREADY low -> RDATA held.
